// File: rtl/dm_load_unit_pkg.sv
// Shared load-unit definitions: op codes, exception codes, address map and fault classification.
`timescale 1ns/1ps
package dm_load_unit_pkg;

  localparam int IDX_W = 12;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ld_op_e;

  localparam logic [4:0] EXC_AdEL = 5'd4;
  localparam logic [4:0] EXC_AdES = 5'd5;
  localparam logic [4:0] EXC_Ri   = 5'd10;
  localparam logic [4:0] EXC_Ov   = 5'd12;

  localparam logic [31:0] DM_START    = 32'h0000_0000;
  localparam logic [31:0] DM_END      = 32'h0000_2FFF;
  localparam logic [31:0] TIME0_START = 32'h0000_7F00;
  localparam logic [31:0] TIME0_END   = 32'h0000_7F0B;
  localparam logic [31:0] TIME1_START = 32'h0000_7F10;
  localparam logic [31:0] TIME1_END   = 32'h0000_7F1B;

  typedef enum logic [1:0] {
    SEL_DM     = 2'd0,
    SEL_TIMER0 = 2'd1,
    SEL_TIMER1 = 2'd2,
    SEL_NONE   = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       exc;
    logic [4:0] code;
  } fault_t;

  // DM_START is zero, so only the upper bound needs comparing.
  function automatic rd_sel_e addr_region(input logic [31:0] addr);
    if (addr <= DM_END) begin
      return SEL_DM;
    end else if (addr >= TIME0_START && addr <= TIME0_END) begin
      return SEL_TIMER0;
    end else if (addr >= TIME1_START && addr <= TIME1_END) begin
      return SEL_TIMER1;
    end else begin
      return SEL_NONE;
    end
  endfunction

  function automatic fault_t load_fault(input logic [2:0] op, input logic [31:0] addr);
    fault_t  f;
    rd_sel_e region;
    region = addr_region(addr);
    f.exc  = 1'b1;
    f.code = EXC_AdEL;
    if (op > LD_LHU) begin
      f.code = EXC_Ri;
    end else if ((op == LD_LW && addr[1:0] != 2'd0) ||
                 ((op == LD_LH || op == LD_LHU) && addr[0] != 1'b0)) begin
      f.code = EXC_AdEL;
    end else if (region == SEL_NONE) begin
      f.code = EXC_AdEL;
    end else if (region != SEL_DM && op != LD_LW) begin
      f.code = EXC_AdEL;
    end else begin
      f.exc  = 1'b0;
      f.code = 5'd0;
    end
    return f;
  endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// Request, memory-read and response bundle of the load unit; slave = load unit side.
`timescale 1ns/1ps
interface dm_load_unit_if;
  import dm_load_unit_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [2:0]       req_op;
  logic [31:0]      req_pc;
  logic             mem_rd_en;
  logic [1:0]       mem_rd_sel;
  logic [IDX_W-1:0] mem_rd_idx;
  logic [31:0]      mem_rd_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_exc;
  logic [4:0]       resp_exccode;
  logic [31:0]      resp_pc;

  modport slave (
    input  req_valid, req_addr, req_op, req_pc, mem_rd_data, resp_ready,
    output req_ready, mem_rd_en, mem_rd_sel, mem_rd_idx,
           resp_valid, resp_data, resp_exc, resp_exccode, resp_pc
  );

  modport master (
    output req_valid, req_addr, req_op, req_pc, mem_rd_data, resp_ready,
    input  req_ready, mem_rd_en, mem_rd_sel, mem_rd_idx,
           resp_valid, resp_data, resp_exc, resp_exccode, resp_pc
  );
endinterface

// File: rtl/dm_load_unit_load_extract.sv
// Combinational byte/half selection and sign/zero extension of a returned memory word.
`timescale 1ns/1ps
module load_extract
  import dm_load_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane, then extend according to the op.
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    data_o = word_i;
    case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'd0;
    endcase
    if (off_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (op_i)
      LD_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      LD_LBU:  data_o = {24'd0, byte_s};
      LD_LH:   data_o = {{16{half_s[15]}}, half_s};
      LD_LHU:  data_o = {16'd0, half_s};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Load unit: classifies, issues one synchronous word read, extracts and returns via valid/ready.
// Optional: define LOAD_TRACE_EN to print a trace line per accepted non-faulting response.
`timescale 1ns/1ps
module dm_load_unit
  import dm_load_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  dm_load_unit_if.slave bus,
  output logic          busy_o
);

  state_e      state_q;
  logic [1:0]  off_q;
  logic [2:0]  op_q;
  logic [31:0] pc_q;
  logic        resp_valid_q;
  logic        resp_exc_q;
  logic [4:0]  resp_exccode_q;
  logic [31:0] resp_data_q;
  fault_t      fault_s;
  rd_sel_e     region_s;
  logic        accept_s;
  logic [31:0] ext_data_s;

  assign fault_s  = load_fault(bus.req_op, bus.req_addr);
  assign region_s = addr_region(bus.req_addr);
  assign accept_s = (state_q == ST_IDLE) && bus.req_valid;

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign bus.mem_rd_en  = accept_s && !fault_s.exc;
  assign bus.mem_rd_sel = (region_s == SEL_NONE) ? SEL_DM : region_s;
  assign bus.mem_rd_idx = (region_s == SEL_TIMER0 || region_s == SEL_TIMER1) ?
                          {{(IDX_W-2){1'b0}}, bus.req_addr[3:2]} :
                          bus.req_addr[IDX_W+1:2];

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_exc     = resp_exc_q;
  assign bus.resp_exccode = resp_exccode_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_pc      = pc_q;

  load_extract u_extract (
    .word_i (bus.mem_rd_data),
    .off_i  (off_q),
    .op_i   (op_q),
    .data_o (ext_data_s)
  );

  // Load FSM; faults skip WAIT and go straight to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      off_q          <= 2'd0;
      op_q           <= 3'd0;
      pc_q           <= 32'd0;
      resp_valid_q   <= 1'b0;
      resp_exc_q     <= 1'b0;
      resp_exccode_q <= 5'd0;
      resp_data_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            off_q <= bus.req_addr[1:0];
            op_q  <= bus.req_op;
            pc_q  <= bus.req_pc;
            if (fault_s.exc) begin
              resp_exc_q     <= 1'b1;
              resp_exccode_q <= fault_s.code;
              resp_data_q    <= 32'd0;
              resp_valid_q   <= 1'b1;
              state_q        <= ST_RESP;
            end else begin
              resp_exc_q     <= 1'b0;
              resp_exccode_q <= 5'd0;
              state_q        <= ST_WAIT;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          resp_data_q  <= ext_data_s;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LOAD_TRACE_EN
  logic [29:0] trace_word_q;

  // Word address of the in-flight load, kept only for the trace line.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_word_q <= 30'd0;
    end else if (accept_s) begin
      trace_word_q <= bus.req_addr[31:2];
    end else begin
      trace_word_q <= trace_word_q;
    end
  end

  // One trace line per handed-off non-faulting load.
  always_ff @(posedge clk) begin
    if (!reset && resp_valid_q && bus.resp_ready && !resp_exc_q) begin
      $display("%d@%h: %h <= *%h", $time, pc_q, resp_data_q, {trace_word_q, 2'b00});
    end
  end
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed self-checking bench for dm_load_unit with a behavioural one-cycle-latency memory.
`timescale 1ns/1ps
module tb_dm_load_unit;
  import dm_load_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_strobes = 0;

  dm_load_unit_if bus ();

  dm_load_unit dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [1:0] sel, input logic [11:0] idx);
    if (sel == 2'd0) begin
      return (idx == 12'd0) ? 32'h8081_7F01 : (32'hD000_0000 | {20'd0, idx});
    end else begin
      return 32'hA000_0000 | {22'd0, sel, 8'h00} | {20'd0, idx};
    end
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem_word(bus.mem_rd_sel, bus.mem_rd_idx);
      n_strobes       <= n_strobes + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] pc,
                         input bit exp_exc, input logic [4:0] exp_code, input logic [31:0] exp_data,
                         input logic [1:0] exp_sel, input logic [11:0] exp_idx, input int hold);
    int s0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_pc    = pc;
    #1;
    check_eq("req_ready_idle", bus.req_ready, 1'b1);
    check_eq("rd_en_accept", bus.mem_rd_en, !exp_exc);
    if (!exp_exc) begin
      check_eq("rd_sel", bus.mem_rd_sel, exp_sel);
      check_eq("rd_idx", bus.mem_rd_idx, exp_idx);
    end
    s0 = n_strobes;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check_eq("valid_T1", bus.resp_valid, exp_exc);
    if (!exp_exc) begin
      @(negedge clk);
      #1;
      check_eq("valid_T2", bus.resp_valid, 1'b1);
    end
    check_eq("strobes", n_strobes - s0, exp_exc ? 0 : 1);
    check_eq("resp_exc", bus.resp_exc, exp_exc);
    if (exp_exc) begin
      check_eq("resp_code", bus.resp_exccode, exp_code);
    end
    check_eq("resp_data", bus.resp_data, exp_data);
    check_eq("resp_pc", bus.resp_pc, pc);
    check_eq("req_ready_busy", bus.req_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check_eq("hold_valid", bus.resp_valid, 1'b1);
      check_eq("hold_data", bus.resp_data, exp_data);
      check_eq("hold_pc", bus.resp_pc, pc);
      check_eq("hold_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("released_valid", bus.resp_valid, 1'b0);
    check_eq("released_ready", bus.req_ready, 1'b1);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int acc[$];
    bit ghost;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 3'd0;
    bus.req_addr    = 32'd0;
    bus.req_pc      = 32'd0;
    bus.resp_ready  = 1'b0;
    bus.mem_rd_data = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", bus.resp_valid, 1'b0);
    check_eq("rst_exc", bus.resp_exc, 1'b0);
    check_eq("rst_data", bus.resp_data, 32'd0);
    check_eq("rst_code", bus.resp_exccode, 5'd0);
    check_eq("rst_pc", bus.resp_pc, 32'd0);
    check_eq("rst_rd_en", bus.mem_rd_en, 1'b0);
    check_eq("rst_ready", bus.req_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Extraction from word 0x8081_7F01
    do_load(3'd1, 32'h0000_0001, 32'h0040_0000, 1'b0, 5'd0, 32'h0000_007F, 2'd0, 12'd0, 0);
    do_load(3'd1, 32'h0000_0000, 32'h0040_0004, 1'b0, 5'd0, 32'h0000_0001, 2'd0, 12'd0, 0);
    do_load(3'd2, 32'h0000_0003, 32'h0040_0008, 1'b0, 5'd0, 32'h0000_0080, 2'd0, 12'd0, 0);
    do_load(3'd1, 32'h0000_0003, 32'h0040_000C, 1'b0, 5'd0, 32'hFFFF_FF80, 2'd0, 12'd0, 0);
    do_load(3'd3, 32'h0000_0002, 32'h0040_0010, 1'b0, 5'd0, 32'hFFFF_8081, 2'd0, 12'd0, 0);
    do_load(3'd4, 32'h0000_0002, 32'h0040_0014, 1'b0, 5'd0, 32'h0000_8081, 2'd0, 12'd0, 0);
    do_load(3'd0, 32'h0000_0000, 32'h0040_0018, 1'b0, 5'd0, 32'h8081_7F01, 2'd0, 12'd0, 0);
    do_load(3'd4, 32'h0000_0000, 32'h0040_001C, 1'b0, 5'd0, 32'h0000_7F01, 2'd0, 12'd0, 0);

    // Faults
    do_load(3'd0, 32'h0000_0002, 32'h0040_0020, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);
    do_load(3'd0, 32'h0000_3000, 32'h0040_0024, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);
    do_load(3'd6, 32'h0000_0000, 32'h0040_0028, 1'b1, 5'd10, 32'd0, 2'd0, 12'd0, 0);
    do_load(3'd7, 32'h0000_0003, 32'h0040_002C, 1'b1, 5'd10, 32'd0, 2'd0, 12'd0, 0);
    do_load(3'd3, 32'h0000_7F08, 32'h0040_0030, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);
    do_load(3'd3, 32'h0000_0001, 32'h0040_0034, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);
    do_load(3'd0, 32'h0000_7F0C, 32'h0040_0038, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);
    do_load(3'd1, 32'h0000_7F1B, 32'h0040_003C, 1'b1, 5'd4,  32'd0, 2'd0, 12'd0, 0);

    // Boundaries and timers
    do_load(3'd0, 32'h0000_2FFC, 32'h0040_0040, 1'b0, 5'd0, 32'hD000_0BFF, 2'd0, 12'hBFF, 0);
    do_load(3'd0, 32'h0000_7F08, 32'h0040_0044, 1'b0, 5'd0, 32'hA000_0102, 2'd1, 12'd2, 0);
    do_load(3'd0, 32'h0000_7F18, 32'h0040_0048, 1'b0, 5'd0, 32'hA000_0202, 2'd2, 12'd2, 0);

    // Backpressure
    do_load(3'd0, 32'h0000_0010, 32'h0040_004C, 1'b0, 5'd0, 32'hD000_0004, 2'd0, 12'd4, 5);
    do_load(3'd0, 32'h0000_0006, 32'h0040_0050, 1'b1, 5'd4, 32'd0, 2'd0, 12'd0, 3);

    // Back-to-back with resp_ready held high
    @(negedge clk);
    #1;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'd0;
    bus.req_addr   = 32'h0000_0004;
    bus.req_pc     = 32'h0040_0054;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready) begin
        acc.push_back(c);
      end
      if (bus.resp_valid) begin
        check_eq("b2b_data", bus.resp_data, 32'hD000_0001);
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check_eq("b2b_count", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) begin
      check_eq("b2b_gap", acc[i] - acc[i-1], 3);
    end
    @(negedge clk);

    // Reset while in WAIT drops the load
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0000_0008;
    bus.req_pc    = 32'h0040_0058;
    @(negedge clk);
    #1;
    check_eq("wait_busy", busy, 1'b1);
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rstw_valid", bus.resp_valid, 1'b0);
    check_eq("rstw_ready", bus.req_ready, 1'b1);
    reset          = 1'b0;
    bus.resp_ready = 1'b1;
    ghost          = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid) begin
        ghost = 1'b1;
      end
    end
    check_eq("no_ghost", ghost, 1'b0);
    bus.resp_ready = 1'b0;

    // Recovery after reset
    do_load(3'd2, 32'h0000_0001, 32'h0040_005C, 1'b0, 5'd0, 32'h0000_007F, 2'd0, 12'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- Read-side companion to the data-memory store path.
- Accepts load requests from the MEM stage and classifies the address region.
- Detects AdEL and Ri faults, issues one synchronous word read, then byte/half-extracts and sign/zero-extends the returned word.
- Returns the result to WB through a valid/ready handshake.

Parameters:
IDX_W, 12, word-index width driven to memory (4096 words)
EXC_AdEL, 4, exception code for illegal load address
EXC_Ri, 10, exception code for reserved load op

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  load request present
req_ready  out  1  unit can accept a request
req_addr  in  32  byte address
req_op  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5-7 reserved
req_pc  in  32  PC of the load instruction
mem_rd_en  out  1  read strobe
mem_rd_sel  out  2  0 DM, 1 timer0, 2 timer1
mem_rd_idx  out  12  word index (addr[13:2] for DM, addr[3:2] zero-extended for timers)
mem_rd_data  in  32  read word, valid on the cycle after mem_rd_en
resp_valid  out  1  result/exception available
resp_ready  in  1  WB accepts result
resp_data  out  32  extended load data (0 when resp_exc)
resp_exc  out  1  exception flag
resp_exccode  out  5  exception code
resp_pc  out  32  PC of the responding load
busy  out  1  state != IDLE

Behaviour:
- Reset (clk, reset synchronous, active-high) forces:
  - state IDLE, mem_rd_en 0, resp_valid 0, resp_exc 0.
  - resp_data, resp_exccode, resp_pc all 0.
  - Reset mid-operation discards any in-flight request and any unaccepted response.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
- IDLE, on req_valid:
  - Latch addr, op and pc.
  - Legal request: mem_rd_en = 1 for exactly this cycle, mem_rd_sel/mem_rd_idx driven combinationally from req_addr; go to WAIT.
  - Faulting request: no memory strobe; go to RESP with resp_exc = 1.
- WAIT (one cycle):
  - Capture mem_rd_data, apply extraction, register into resp_data; go to RESP.
- RESP:
  - resp_valid = 1; all resp_* outputs are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE.
  - resp_ready already high on entry still costs the RESP cycle.
- Latency and throughput:
  - Legal load: accept at T, resp_valid at T+2.
  - Faulting load: resp_valid at T+1.
  - Throughput: one load per 3 cycles.
- Fault priority (highest first):
  - Ri: op 5-7.
  - AdEL misalignment: lw with addr[1:0] != 0, or lh/lhu with addr[0] != 0.
  - AdEL region: address outside DM 0x0000_0000-0x0000_2FFF, timer0 0x0000_7F00-0x0000_7F0B, timer1 0x0000_7F10-0x0000_7F1B.
  - AdEL non-word timer access: lb/lbu/lh/lhu to a timer region.
- Extraction on the latched addr[1:0]:
  - lb/lbu: byte k = word[8k+7:8k], sign-/zero-extended to 32 bits.
  - lh/lhu: addr[1] = 0 takes [15:0], addr[1] = 1 takes [31:16], then extended.
  - lw: word unchanged.
- Boundary addresses:
  - 0x2FFC lw is legal; 0x3000 is AdEL.
  - 0x7F0C is AdEL; 0x7F1B lb is AdEL (timer region, non-word access).
- req_valid in WAIT/RESP is ignored (not accepted); the requester holds its inputs until req_ready.

Optional Feature:
- Macro: LOAD_TRACE_EN.
- Defined: on each accepted response without exception, $display("%d@%h: %h <= *%h", $time, resp_pc, resp_data, {addr[31:2],2'b00}).
- Not defined: no display; RTL is functionally identical.

Decomposition:
- Shared package/header holds:
  - load op codes (LD_LW..LD_LHU);
  - exception codes 4/10/5/12;
  - region bounds dm_start/dm_end, time0_start/end, time1_start/end;
  - region select codes for mem_rd_sel.
- One sub-module, load_extract: purely combinational (word, addr[1:0], op) -> 32-bit result; instantiated once in the WAIT datapath.

Test Plan:
- DM word 0x0 = 0x8081_7F01; lb @0x1 -> resp_data 0x0000_007F; lb @0x0 -> 0x0000_0001; lbu @0x3 -> 0x0000_0080; lb @0x3 -> 0xFFFF_FF80; each resp_valid 2 cycles after accept.
- Same word: lh @0x2 -> 0xFFFF_8081; lhu @0x2 -> 0x0000_8081; lw @0x0 -> 0x8081_7F01.
- lw @0x0002 -> resp_exc = 1, code 4, mem_rd_en never asserted, resp_valid 1 cycle after accept.
- Out-of-range and reserved:
  - lw @0x3000 -> code 4.
  - op 6 @0x0 -> code 10.
  - lh @0x7F08 -> code 4.
  - lw @0x7F08 -> mem_rd_sel 1, idx 2, data passed through.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_* stable, req_ready 0; resp_ready 1 -> IDLE next cycle; back-to-back loads accepted every 3 cycles.
- Reset asserted in WAIT -> next cycle resp_valid 0, req_ready 1, and no response is ever produced for the dropped load.
